// File: rtl/fifo_s1_sf_pkg.sv
// Shared constants and pointer helper for the fifo_s1_sf block.
// Pure definitions; no logic, no latency, no flow control.
package fifo_s1_sf_pkg;

  localparam int ERR_MODE_CURRENT = 2;
  localparam int MAX_WIDTH        = 256;
  localparam int MAX_DEPTH        = 256;

  // Modulo-depth increment; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned d);
    return (p == d - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_s1_sf_ctl.sv
// FIFO control: pointers, occupancy, registered status flags and error tracking.
// Flags update on the same edge as count; requests beyond full/empty are dropped and flagged.
module fifo_s1_sf_ctl
  import fifo_s1_sf_pkg::*;
#(
  parameter int depth    = 5,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0,
  localparam int AW = (depth > 1) ? $clog2(depth) : 1,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req_n_i,
  input  logic          pop_req_n_i,
  input  logic          diag_n_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          empty_o,
  output logic          almost_empty_o,
  output logic          half_full_o,
  output logic          almost_full_o,
  output logic          full_o,
  output logic          error_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, almost_empty_q, half_full_q, almost_full_q, full_q, error_q;
  logic          error_d;
  logic          is_empty, is_full, push_ok, pop_ok, ovf, unf;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(depth));
  assign pop_ok   = ~pop_req_n_i & ~is_empty;
  // A pop frees the slot a simultaneous push needs, so push+pop at full is legal.
  assign push_ok  = ~push_req_n_i & (~is_full | pop_ok);
  assign ovf      = ~push_req_n_i & is_full & ~pop_ok;
  assign unf      = ~pop_req_n_i & is_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    if (!diag_n_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), depth));
      if (pop_ok)  rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), depth));
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (err_mode == ERR_MODE_CURRENT) error_d = ovf | unf;
      else                              error_d = error_q | ovf | unf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      error_q        <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      half_full_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      full_q         <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      error_q        <= error_d;
      empty_q        <= (cnt_d == '0);
      almost_empty_q <= (cnt_d <= CW'(ae_level));
      half_full_q    <= (cnt_d >= CW'((depth + 1) / 2));
      almost_full_q  <= (cnt_d >= CW'(depth - af_level));
      full_q         <= (cnt_d == CW'(depth));
    end
  end

  assign wr_en_o        = push_ok & diag_n_i;
  assign wr_addr_o      = wr_ptr_q;
  assign rd_addr_o      = rd_ptr_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = almost_empty_q;
  assign half_full_o    = half_full_q;
  assign almost_full_o  = almost_full_q;
  assign full_o         = full_q;
  assign error_o        = error_q;

endmodule

// File: rtl/fifo_s1_sf.sv
// Single-clock FIFO with fall-through read: a pushed word is on data_out one edge later.
// No backpressure handshake; push at full / pop at empty are dropped and raise error.
module fifo_s1_sf
  import fifo_s1_sf_pkg::*;
#(
  parameter int width    = 16,
  parameter int depth    = 5,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0,
  parameter int rst_mode = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  if (width < 1 || width > MAX_WIDTH) begin : g_bad_width
    $error("fifo_s1_sf: width must be 1..256");
  end
  if (depth < 2 || depth > MAX_DEPTH) begin : g_bad_depth
    $error("fifo_s1_sf: depth must be 2..256");
  end
  if (ae_level < 1 || ae_level > depth - 1 || af_level < 1 || af_level > depth - 1) begin : g_bad_lvl
    $error("fifo_s1_sf: ae_level/af_level must be 1..depth-1");
  end
  if (err_mode < 0 || err_mode > 2 || rst_mode < 0 || rst_mode > 1) begin : g_bad_mode
    $error("fifo_s1_sf: err_mode must be 0..2, rst_mode 0..1");
  end

  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [width-1:0] mem_q [depth];

  fifo_s1_sf_ctl #(
    .depth    (depth),
    .ae_level (ae_level),
    .af_level (af_level),
    .err_mode (err_mode)
  ) u_ctl (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_req_n_i   (push_req_n),
    .pop_req_n_i    (pop_req_n),
    .diag_n_i       (diag_n),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .rd_addr_o      (rd_addr),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .half_full_o    (half_full),
    .almost_full_o  (almost_full),
    .full_o         (full),
    .error_o        (error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  // Popped words are not cleared; data_out is only meaningful while !empty.
  assign data_out = mem_q[rd_addr];

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Directed bench for fifo_s1_sf with a queue-based reference model checked every cycle.
module tb_fifo_s1_sf;

  localparam int W = 16;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push_req_n = 1'b1;
  logic         pop_req_n = 1'b1;
  logic         diag_n = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         empty, almost_empty, half_full, almost_full, full, error;
  logic [W-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  bit           merr = 1'b0;
  int           mn;
  int           cn;
  bit           mpu, mpo;

  always #5 clk = ~clk;

  fifo_s1_sf #(
    .width(W), .depth(D), .ae_level(1), .af_level(1), .err_mode(0), .rst_mode(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_req_n   (push_req_n),
    .pop_req_n    (pop_req_n),
    .diag_n       (diag_n),
    .data_in      (data_in),
    .empty        (empty),
    .almost_empty (almost_empty),
    .half_full    (half_full),
    .almost_full  (almost_full),
    .full         (full),
    .error        (error),
    .data_out     (data_out)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words plus a sticky error bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      merr = 1'b0;
    end else if (!diag_n) begin
      mq.delete();
    end else begin
      mpu = !push_req_n;
      mpo = !pop_req_n;
      mn  = mq.size();
      if (mpo && mn == 0) merr = 1'b1;
      if (mpu && mn == D && !mpo) merr = 1'b1;
      if (mpo && mn > 0) void'(mq.pop_front());
      if (mpu && (mn < D || mpo)) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cn = mq.size();
      chk("m_empty",        W'(empty),        W'(cn == 0));
      chk("m_almost_empty", W'(almost_empty), W'(cn <= 1));
      chk("m_half_full",    W'(half_full),    W'(cn >= (D + 1) / 2));
      chk("m_almost_full",  W'(almost_full),  W'(cn >= D - 1));
      chk("m_full",         W'(full),         W'(cn == D));
      chk("m_error",        W'(error),        W'(merr));
      if (cn > 0) chk("m_data_out", data_out, mq[0]);
    end
  end

  task automatic step(input logic pu, input logic po, input logic dg, input logic [W-1:0] d);
    push_req_n = pu;
    pop_req_n  = po;
    diag_n     = dg;
    data_in    = d;
    @(negedge clk);
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    diag_n     = 1'b1;
    data_in    = '0;
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty",        W'(empty),        16'd1);
    chk("rst_almost_empty", W'(almost_empty), 16'd1);
    chk("rst_half_full",    W'(half_full),    16'd0);
    chk("rst_almost_full",  W'(almost_full),  16'd0);
    chk("rst_full",         W'(full),         16'd0);
    chk("rst_error",        W'(error),        16'd0);
    chk("rst_data_out",     data_out,         16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < D; i++) begin
      push(16'hA001 + W'(i));
      chk("fill_head",         data_out,         16'hA001);
      chk("fill_almost_empty", W'(almost_empty), W'(i == 0));
      chk("fill_half_full",    W'(half_full),    W'(i >= 2));
      chk("fill_almost_full",  W'(almost_full),  W'(i >= 3));
      chk("fill_full",         W'(full),         W'(i == 4));
    end

    for (int i = 0; i < D; i++) begin
      chk("drain_head", data_out, 16'hA001 + W'(i));
      pop();
    end
    chk("drain_empty", W'(empty), 16'd1);
    chk("drain_error", W'(error), 16'd0);

    for (int i = 0; i < D; i++) push(16'hC000 + W'(i));
    push(16'hBEEF);
    chk("ovf_error", W'(error), 16'd1);
    chk("ovf_full",  W'(full),  16'd1);
    step(1'b1, 1'b1, 1'b1, '0);
    chk("ovf_error_sticky", W'(error), 16'd1);
    for (int i = 0; i < D; i++) begin
      chk("ovf_contents", data_out, 16'hC000 + W'(i));
      pop();
    end
    chk("ovf_error_held", W'(error), 16'd1);

    do_reset();
    chk("rst2_error", W'(error), 16'd0);

    for (int i = 0; i < D; i++) push(16'hD000 + W'(i));
    step(1'b0, 1'b0, 1'b1, 16'hE000);
    chk("fullpp_full",  W'(full),  16'd1);
    chk("fullpp_error", W'(error), 16'd0);
    chk("fullpp_head",  data_out,  16'hD001);
    for (int i = 0; i < D; i++) pop();
    chk("fullpp_empty", W'(empty), 16'd1);

    push(16'hF000);
    push(16'hF001);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 16'hF002 + W'(k));
    chk("wrap_almost_empty", W'(almost_empty), 16'd0);
    chk("wrap_half_full",    W'(half_full),    16'd0);
    chk("wrap_head",         data_out,         16'hF00A);
    pop();
    chk("wrap_next",         data_out,         16'hF00B);
    pop();
    chk("wrap_empty",        W'(empty),        16'd1);
    chk("wrap_error",        W'(error),        16'd0);

    pop();
    chk("unf_error", W'(error), 16'd1);
    do_reset();
    chk("rst3_error", W'(error), 16'd0);

    step(1'b0, 1'b0, 1'b1, 16'h1234);
    chk("emptypp_error", W'(error), 16'd1);
    chk("emptypp_head",  data_out,  16'h1234);
    chk("emptypp_empty", W'(empty), 16'd0);
    do_reset();

    push(16'h0111);
    push(16'h0222);
    push(16'h0333);
    chk("diag_pre_half", W'(half_full), 16'd1);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("diag_empty",        W'(empty),        16'd1);
    chk("diag_almost_empty", W'(almost_empty), 16'd1);
    chk("diag_half_full",    W'(half_full),    16'd0);
    chk("diag_error",        W'(error),        16'd0);
    step(1'b0, 1'b1, 1'b0, 16'h5555);
    chk("diag_push_ignored", W'(empty), 16'd1);
    push(16'h7777);
    chk("diag_after_head",  data_out,  16'h7777);
    chk("diag_after_empty", W'(empty), 16'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
